vx_tex_agent: RTL and testbench
===============================

// Module: vx_tex_agent
// PURPOSE
//  Issue-side partner of the texture unit. Takes TEX instructions from the issue stage and
//  drives the texture unit's request port. Collects its responses and hands them to commit.
//  Forwards texture-CSR writes to the unit only once no texture request is in flight.
//  Tracks outstanding requests per warp so the scheduler can block fences/barriers.
// PARAMETERS
//  CORE_ID      0   core index, used only in trace/assert messages
//  NUM_WARPS    4   warps per core; NW_BITS = clog2(NUM_WARPS)
//  NUM_THREADS  4   lanes per request
//  MAX_PENDING  16  max texture requests in flight per core (credit limit)
// PORTS
//  clk            in   1             core clock
//  reset          in   1             asynchronous, active-high
//  gpu_req_valid  in   1             TEX instruction valid from issue
//  gpu_req_data   in   tex_req_t     {wid,tmask,PC,rd,wb,unit,coords[2][T],lod[T]}
//  gpu_req_ready  out  1             agent accepts instruction
//  csr_wr_valid   in   1             CSR unit write to a tex CSR
//  csr_wr_addr    in   12            CSR address
//  csr_wr_data    in   32            CSR data
//  csr_wr_ready   out  1             CSR write accepted (latched)
//  tex_req_valid  out  1             request to texture unit
//  tex_req_data   out  tex_req_t     request payload
//  tex_req_ready  in   1             texture unit accepts
//  tex_csr_we     out  1             one-cycle CSR write strobe to texture unit
//  tex_csr_addr   out  12            latched CSR address
//  tex_csr_data   out  32            latched CSR data
//  tex_rsp_valid  in   1             response from texture unit
//  tex_rsp_data   in   tex_rsp_t     {wid,tmask,PC,rd,wb,data[T]}
//  tex_rsp_ready  out  1             agent accepts response
//  commit_valid   out  1             writeback to commit stage
//  commit_data    out  tex_rsp_t     registered copy of response
//  commit_ready   in   1             commit accepts
//  warp_pending   out  NUM_WARPS     bit w = warp w has requests outstanding
// BEHAVIOUR
//  Reset: all *_valid, tex_csr_we, warp_pending, counters = 0; FSM = IDLE; csr_wr_ready = 0 in reset.
//  Request path: 2-entry skid buffer; tex_req_valid registered, latency 1 cycle.
//   Full throughput, no bubbles. Payload passes unchanged.
//  gpu_req_ready = state==IDLE & !csr_wr_valid & total_pending<MAX_PENDING & skid not full.
//   CSR writes win ties with instructions.
//  Counters: cnt[w] (clog2(MAX_PENDING+1) bits) and total_pending.
//   +1 on gpu_req fire for its wid; -1 on commit fire for commit_data.wid.
//   Both in the same cycle for the same warp: count unchanged.
//   Decrement at 0: saturate at 0 and fire an assertion.
//  warp_pending[w] is registered and equals (cnt[w]!=0), one cycle after the counter update.
//  Response path: single pipe register; tex_rsp_ready = !commit_valid | commit_ready.
//   Order preserved; nothing dropped under commit backpressure.
//  CSR FSM (states IDLE, DRAIN, WRITE):
//   IDLE:  csr_wr_ready=1; on csr_wr_valid latch addr/data -> DRAIN.
//   DRAIN: gpu_req_ready=0 and csr_wr_ready=0; when total_pending==0 -> WRITE.
//   WRITE: tex_csr_we=1 for exactly one cycle -> IDLE.
//   Minimum accept-to-strobe latency is 2 cycles; there is no bypass.
//  Reset mid-operation: in-flight skid, pipe-register contents and a latched CSR write are discarded.
// CONFIGURATION
//  TEX_PERF_EN defined: adds outputs perf_tex_reqs[43:0] and perf_tex_lat[43:0].
//   perf_tex_reqs counts gpu_req fires; perf_tex_lat adds total_pending every cycle.
//   Both reset to 0 and wrap on overflow.
//  TEX_PERF_EN undefined: those ports and their logic are absent.
// STRUCTURE
//  Package vx_tex_types_pkg holds tex_req_t, tex_rsp_t, tex_agent_state_e (IDLE/DRAIN/WRITE)
//   and TEX_CSR_ADDR_W=12.
//  Sub-module vx_tex_skid_buf (2-entry elastic buffer, DATAW param) is used on the request path.
// TESTING
//  1 gpu_req wid0,1,2 on consecutive cycles, tex_req_ready=1
//    -> tex_req_valid on cycles 1..3 in order; warp_pending=4'b0111.
//  2 16 requests, no responses -> gpu_req_ready=0 for the 17th.
//    One commit fire -> 17th accepted on the next cycle.
//  3 CSR write 0x7C1/0xDEADBEEF with 2 pending -> tex_csr_we=0 until both commits.
//    Then a 1-cycle strobe with 0x7C1/0xDEADBEEF; gpu_req_ready=0 throughout.
//  4 rsp stream of 6 with commit_ready=0 for 5 cycles -> all 6 committed in order.
//    tex_rsp_ready=0 while the register is full.
//  5 wid3 cnt=1: gpu_req fire and commit fire for wid3 in the same cycle -> cnt stays 1.
//    warp_pending[3]=1.
//  6 reset asserted during DRAIN -> outputs 0 immediately; FSM IDLE; no tex_csr_we after release.

Source files
------------

// File: rtl/vx_tex_types_pkg.sv
// Shared types for the texture agent: request/response payloads and CSR FSM states.
package vx_tex_types_pkg;

    localparam int TEX_CSR_ADDR_W  = 12;
    localparam int TEX_NUM_WARPS   = 4;
    localparam int TEX_NUM_THREADS = 4;
    localparam int TEX_NW_BITS     = $clog2(TEX_NUM_WARPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WRITE = 2'd2
    } tex_agent_state_e;

    typedef struct packed {
        logic [TEX_NW_BITS-1:0]                       wid;
        logic [TEX_NUM_THREADS-1:0]                   tmask;
        logic [31:0]                                  pc;
        logic [4:0]                                   rd;
        logic                                         wb;
        logic [1:0]                                   unit;
        logic [1:0][TEX_NUM_THREADS-1:0][31:0]        coords;
        logic [TEX_NUM_THREADS-1:0][31:0]             lod;
    } tex_req_t;

    typedef struct packed {
        logic [TEX_NW_BITS-1:0]                       wid;
        logic [TEX_NUM_THREADS-1:0]                   tmask;
        logic [31:0]                                  pc;
        logic [4:0]                                   rd;
        logic                                         wb;
        logic [TEX_NUM_THREADS-1:0][31:0]             data;
    } tex_rsp_t;

endpackage

// File: rtl/vx_tex_skid_buf.sv
// Two-entry elastic buffer with a registered output; sustains one transfer per cycle.
module vx_tex_skid_buf #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    input  logic             out_ready
);

    logic [DATAW-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage needs no reset: count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
        end
    end

endmodule

// File: rtl/vx_tex_agent.sv
// Issue-side texture agent: request skid, response pipe, per-warp pending counters, CSR drain FSM.
// Optional TEX_PERF_EN adds request-count and pending-latency performance counters.
module vx_tex_agent
    import vx_tex_types_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int NUM_WARPS   = TEX_NUM_WARPS,
    parameter int NUM_THREADS = TEX_NUM_THREADS,
    parameter int MAX_PENDING = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      gpu_req_valid,
    input  tex_req_t                  gpu_req_data,
    output logic                      gpu_req_ready,
    input  logic                      csr_wr_valid,
    input  logic [TEX_CSR_ADDR_W-1:0] csr_wr_addr,
    input  logic [31:0]               csr_wr_data,
    output logic                      csr_wr_ready,
    output logic                      tex_req_valid,
    output tex_req_t                  tex_req_data,
    input  logic                      tex_req_ready,
    output logic                      tex_csr_we,
    output logic [TEX_CSR_ADDR_W-1:0] tex_csr_addr,
    output logic [31:0]               tex_csr_data,
    input  logic                      tex_rsp_valid,
    input  tex_rsp_t                  tex_rsp_data,
    output logic                      tex_rsp_ready,
    output logic                      commit_valid,
    output tex_rsp_t                  commit_data,
    input  logic                      commit_ready,
    output logic [NUM_WARPS-1:0]      warp_pending
`ifdef TEX_PERF_EN
    ,
    output logic [43:0]               perf_tex_reqs,
    output logic [43:0]               perf_tex_lat
`endif
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam int REQ_W = $bits(tex_req_t);

    tex_agent_state_e          state;
    logic [TEX_CSR_ADDR_W-1:0] csr_addr_q;
    logic [31:0]               csr_data_q;
    logic [CNT_W-1:0]          total_pending;
    logic                      skid_ready;
    logic                      req_fire;
    logic                      rsp_fire;
    logic                      commit_fire;
    logic [REQ_W-1:0]          skid_out;

    // CSR writes take priority over instructions and freeze issue until drained.
    assign gpu_req_ready = !reset && (state == IDLE) && !csr_wr_valid &&
                           (total_pending < CNT_W'(MAX_PENDING)) && skid_ready;
    assign csr_wr_ready  = !reset && (state == IDLE);
    assign req_fire      = gpu_req_valid && gpu_req_ready;
    assign tex_rsp_ready = !commit_valid || commit_ready;
    assign rsp_fire      = tex_rsp_valid && tex_rsp_ready;
    assign commit_fire   = commit_valid && commit_ready;
    assign tex_csr_we    = (state == WRITE);
    assign tex_csr_addr  = csr_addr_q;
    assign tex_csr_data  = csr_data_q;
    assign tex_req_data  = tex_req_t'(skid_out);

    vx_tex_skid_buf #(.DATAW(REQ_W)) req_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (req_fire),
        .in_data   (gpu_req_data),
        .in_ready  (skid_ready),
        .out_valid (tex_req_valid),
        .out_data  (skid_out),
        .out_ready (tex_req_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            csr_addr_q <= '0;
            csr_data_q <= '0;
        end else begin
            case (state)
                IDLE: if (csr_wr_valid) begin
                    state      <= DRAIN;
                    csr_addr_q <= csr_wr_addr;
                    csr_data_q <= csr_wr_data;
                end
                DRAIN: if (total_pending == '0) state <= WRITE;
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_pending <= '0;
        end else if (req_fire && !commit_fire) begin
            total_pending <= total_pending + CNT_W'(1);
        end else if (commit_fire && !req_fire && total_pending != '0) begin
            total_pending <= total_pending - CNT_W'(1);
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        logic             inc;
        logic             dec;
        logic [CNT_W-1:0] cnt;
        logic             pend_q;

        assign inc             = req_fire && (gpu_req_data.wid == TEX_NW_BITS'(w));
        assign dec             = commit_fire && (commit_data.wid == TEX_NW_BITS'(w));
        assign warp_pending[w] = pend_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt    <= '0;
                pend_q <= 1'b0;
            end else begin
                pend_q <= (cnt != '0);
                if (inc && !dec) begin
                    cnt <= cnt + CNT_W'(1);
                end else if (dec && !inc) begin
                    assert (cnt != '0)
                        else $error("core%0d: texture pending underflow on warp %0d", CORE_ID, w);
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

    // Response pipe register: loads whenever it is empty or being drained this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_valid <= 1'b0;
            commit_data  <= '0;
        end else if (rsp_fire) begin
            commit_valid <= 1'b1;
            commit_data  <= tex_rsp_data;
        end else if (commit_ready) begin
            commit_valid <= 1'b0;
        end
    end

`ifdef TEX_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_tex_reqs <= '0;
            perf_tex_lat  <= '0;
        end else begin
            if (req_fire) perf_tex_reqs <= perf_tex_reqs + 44'd1;
            perf_tex_lat <= perf_tex_lat + 44'(total_pending);
        end
    end
`endif

endmodule

// File: tb/tb_vx_tex_agent.sv
// Directed bench for vx_tex_agent: issue order, credit limit, CSR drain, commit backpressure, reset.
module tb_vx_tex_agent;
    import vx_tex_types_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        gpu_req_valid;
    tex_req_t    gpu_req_data;
    logic        gpu_req_ready;
    logic        csr_wr_valid;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        csr_wr_ready;
    logic        tex_req_valid;
    tex_req_t    tex_req_data;
    logic        tex_req_ready;
    logic        tex_csr_we;
    logic [11:0] tex_csr_addr;
    logic [31:0] tex_csr_data;
    logic        tex_rsp_valid;
    tex_rsp_t    tex_rsp_data;
    logic        tex_rsp_ready;
    logic        commit_valid;
    tex_rsp_t    commit_data;
    logic        commit_ready;
    logic [3:0]  warp_pending;

    int   tests = 0;
    int   fails = 0;
    int   ri;
    int   ci;
    logic fire;

    vx_tex_agent dut (
        .clk           (clk),
        .reset         (reset),
        .gpu_req_valid (gpu_req_valid),
        .gpu_req_data  (gpu_req_data),
        .gpu_req_ready (gpu_req_ready),
        .csr_wr_valid  (csr_wr_valid),
        .csr_wr_addr   (csr_wr_addr),
        .csr_wr_data   (csr_wr_data),
        .csr_wr_ready  (csr_wr_ready),
        .tex_req_valid (tex_req_valid),
        .tex_req_data  (tex_req_data),
        .tex_req_ready (tex_req_ready),
        .tex_csr_we    (tex_csr_we),
        .tex_csr_addr  (tex_csr_addr),
        .tex_csr_data  (tex_csr_data),
        .tex_rsp_valid (tex_rsp_valid),
        .tex_rsp_data  (tex_rsp_data),
        .tex_rsp_ready (tex_rsp_ready),
        .commit_valid  (commit_valid),
        .commit_data   (commit_data),
        .commit_ready  (commit_ready),
        .warp_pending  (warp_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
            else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic tex_req_t mk_req(input int w);
        tex_req_t r;
        r              = '0;
        r.wid          = TEX_NW_BITS'(w);
        r.tmask        = '1;
        r.pc           = 32'h1000 + 32'(w);
        r.rd           = 5'(w + 3);
        r.wb           = 1'b1;
        r.coords[0][0] = 32'hC000 + 32'(w);
        r.lod[1]       = 32'h10 + 32'(w);
        return r;
    endfunction

    function automatic tex_rsp_t mk_rsp(input int w, input logic [31:0] d);
        tex_rsp_t r;
        r         = '0;
        r.wid     = TEX_NW_BITS'(w);
        r.tmask   = '1;
        r.pc      = 32'h1000 + 32'(w);
        r.wb      = 1'b1;
        r.data[0] = d;
        return r;
    endfunction

    task automatic issue(input int w);
        gpu_req_data  = mk_req(w);
        gpu_req_valid = 1'b1;
        tick();
        gpu_req_valid = 1'b0;
    endtask

    task automatic rsp(input int w, input logic [31:0] d);
        tex_rsp_data  = mk_rsp(w, d);
        tex_rsp_valid = 1'b1;
        tick();
        tex_rsp_valid = 1'b0;
    endtask

    initial begin
        gpu_req_valid = 1'b0;
        gpu_req_data  = '0;
        csr_wr_valid  = 1'b0;
        csr_wr_addr   = '0;
        csr_wr_data   = '0;
        tex_req_ready = 1'b1;
        tex_rsp_valid = 1'b0;
        tex_rsp_data  = '0;
        commit_ready  = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tex_req_valid", 64'(tex_req_valid), 64'd0);
        chk("rst_commit_valid",  64'(commit_valid),  64'd0);
        chk("rst_warp_pending",  64'(warp_pending),  64'd0);
        chk("rst_tex_csr_we",    64'(tex_csr_we),    64'd0);
        chk("rst_csr_wr_ready",  64'(csr_wr_ready),  64'd0);
        reset = 1'b0;
        #1;
        chk("idle_csr_wr_ready",  64'(csr_wr_ready),  64'd1);
        chk("idle_gpu_req_ready", 64'(gpu_req_ready), 64'd1);

        // 1: three warps back to back
        gpu_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            gpu_req_data = mk_req(i);
            tick();
            chk($sformatf("t1_valid%0d", i), 64'(tex_req_valid),   64'd1);
            chk($sformatf("t1_wid%0d", i),   64'(tex_req_data.wid), 64'(i));
            chk($sformatf("t1_pc%0d", i),    64'(tex_req_data.pc),  64'(32'h1000 + i));
        end
        gpu_req_valid = 1'b0;
        chk("t1_pending_lag", 64'(warp_pending), 64'b0011);
        tick();
        chk("t1_pending",   64'(warp_pending),  64'b0111);
        chk("t1_req_idle",  64'(tex_req_valid), 64'd0);
        rsp(0, 32'hA0);
        rsp(1, 32'hA1);
        rsp(2, 32'hA2);
        tick();
        tick();
        chk("t1_drained", 64'(warp_pending), 64'd0);

        // 2: credit limit
        gpu_req_data  = mk_req(0);
        gpu_req_valid = 1'b1;
        repeat (16) tick();
        gpu_req_data = mk_req(1);
        #1;
        chk("t2_full_block", 64'(gpu_req_ready), 64'd0);
        tex_rsp_data  = mk_rsp(0, 32'hB0);
        tex_rsp_valid = 1'b1;
        tick();
        tex_rsp_valid = 1'b0;
        chk("t2_still_block", 64'(gpu_req_ready), 64'd0);
        chk("t2_commit_vld",  64'(commit_valid),  64'd1);
        tick();
        chk("t2_unblock", 64'(gpu_req_ready), 64'd1);
        tick();
        gpu_req_valid = 1'b0;
        chk("t2_17th_valid", 64'(tex_req_valid),    64'd1);
        chk("t2_17th_wid",   64'(tex_req_data.wid), 64'd1);
        for (int i = 0; i < 14; i++) rsp(0, 32'hB1 + 32'(i));

        // 3: CSR write waits for the two remaining requests
        csr_wr_valid = 1'b1;
        csr_wr_addr  = 12'h7C1;
        csr_wr_data  = 32'hDEADBEEF;
        #1;
        chk("t3_csr_ready",  64'(csr_wr_ready),  64'd1);
        chk("t3_tie_block",  64'(gpu_req_ready), 64'd0);
        tick();
        csr_wr_valid = 1'b0;
        csr_wr_addr  = '0;
        csr_wr_data  = '0;
        #1;
        chk("t3_drain_csr_rdy", 64'(csr_wr_ready),  64'd0);
        chk("t3_drain_block",   64'(gpu_req_ready), 64'd0);
        chk("t3_drain_we",      64'(tex_csr_we),    64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_wait_we",    64'(tex_csr_we),    64'd0);
            chk("t3_wait_block", 64'(gpu_req_ready), 64'd0);
        end
        rsp(0, 32'hC0);
        rsp(1, 32'hC1);
        chk("t3_we_one_left", 64'(tex_csr_we), 64'd0);
        tick();
        chk("t3_we_zero_left", 64'(tex_csr_we), 64'd0);
        tick();
        chk("t3_strobe",       64'(tex_csr_we),    64'd1);
        chk("t3_strobe_addr",  64'(tex_csr_addr),  64'h7C1);
        chk("t3_strobe_data",  64'(tex_csr_data),  64'hDEADBEEF);
        chk("t3_strobe_block", 64'(gpu_req_ready), 64'd0);
        tick();
        chk("t3_strobe_end", 64'(tex_csr_we),    64'd0);
        chk("t3_idle_csr",   64'(csr_wr_ready),  64'd1);
        chk("t3_idle_req",   64'(gpu_req_ready), 64'd1);

        // 4: six responses against a stalled commit stage
        gpu_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            gpu_req_data = mk_req(i % 3);
            tick();
        end
        gpu_req_valid = 1'b0;
        ri = 0;
        ci = 0;
        for (int cyc = 0; cyc < 40 && ci < 6; cyc++) begin
            commit_ready  = (cyc >= 5);
            tex_rsp_valid = (ri < 6);
            tex_rsp_data  = mk_rsp(ri % 3, 32'h100 + 32'(ri));
            #1;
            if (commit_valid && commit_ready) begin
                chk($sformatf("t4_data%0d", ci), 64'(commit_data.data[0]), 64'(32'h100 + ci));
                chk($sformatf("t4_wid%0d", ci),  64'(commit_data.wid),     64'(ci % 3));
                ci++;
            end else if (commit_valid) begin
                chk("t4_backpressure", 64'(tex_rsp_ready), 64'd0);
            end
            fire = tex_rsp_valid && tex_rsp_ready;
            tick();
            if (fire) ri++;
        end
        tex_rsp_valid = 1'b0;
        commit_ready  = 1'b1;
        chk("t4_all_committed", 64'(ci), 64'd6);
        tick();
        tick();
        chk("t4_drained", 64'(warp_pending), 64'd0);

        // 5: simultaneous issue and commit on warp 3
        issue(3);
        rsp(3, 32'hD0);
        gpu_req_data  = mk_req(3);
        gpu_req_valid = 1'b1;
        #1;
        chk("t5_ready",     64'(gpu_req_ready), 64'd1);
        chk("t5_commit_on", 64'(commit_valid),  64'd1);
        tick();
        gpu_req_valid = 1'b0;
        tick();
        chk("t5_pending_a", 64'(warp_pending[3]), 64'd1);
        tick();
        chk("t5_pending_b", 64'(warp_pending[3]), 64'd1);
        rsp(3, 32'hD1);
        tick();
        tick();
        chk("t5_drained", 64'(warp_pending), 64'd0);

        // 6: reset while a CSR write is draining
        tex_req_ready = 1'b0;
        issue(0);
        commit_ready = 1'b0;
        rsp(0, 32'hE0);
        csr_wr_valid = 1'b1;
        csr_wr_addr  = 12'h123;
        csr_wr_data  = 32'h1;
        tick();
        csr_wr_valid = 1'b0;
        chk("t6_pre_req_vld",  64'(tex_req_valid),   64'd1);
        chk("t6_pre_commit",   64'(commit_valid),    64'd1);
        chk("t6_pre_csr_rdy",  64'(csr_wr_ready),    64'd0);
        chk("t6_pre_pending",  64'(warp_pending[0]), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_req_vld", 64'(tex_req_valid), 64'd0);
        chk("t6_rst_commit",  64'(commit_valid),  64'd0);
        chk("t6_rst_pending", 64'(warp_pending),  64'd0);
        chk("t6_rst_we",      64'(tex_csr_we),    64'd0);
        chk("t6_rst_csr_rdy", 64'(csr_wr_ready),  64'd0);
        tick();
        tick();
        reset         = 1'b0;
        tex_req_ready = 1'b1;
        commit_ready  = 1'b1;
        #1;
        chk("t6_post_csr_rdy", 64'(csr_wr_ready),  64'd1);
        chk("t6_post_req_rdy", 64'(gpu_req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_post_we",      64'(tex_csr_we),    64'd0);
            chk("t6_post_req_vld", 64'(tex_req_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
